pl_stage_decode: RTL and testbench
==================================

// Module: pl_stage_decode
// PURPOSE
// - Decryption-side pipeline stage: inverse of the encrypt-side compress/encode stage.
// - DecodePoly: reads 896 packed bytes (14-bit LSB-first, 4 coeffs per 7 bytes) and writes 512 16-bit coefficients.
// - Decompress: reads 192 bytes (3-bit LSB-first, 8 coeffs per 3 bytes) and writes 512 coefficients, each ((x*Q)+4)>>3.
// - Both engines run concurrently from one start_stage; done_stage fires when both have finished.
// PARAMETERS
// - N   512    coefficients per polynomial (engines fixed at 14-bit and 3-bit packing)
// - Q   12289  modulus used by decompress and by the range check
// PORTS
// - clk          in   1   clock
// - rst          in   1   synchronous active-high reset
// - en           in   1   global enable; when 0 all state, counters and outputs hold
// - start_stage  in   1   1-cycle start pulse; ignored while busy
// - done_stage   out  1   1-cycle pulse when both engines have finished
// - baddr_r1     out  10  encoded-poly byte RAM read address (0..895)
// - bdo_r1       in   8   encoded-poly byte read data, valid 1 cycle after address
// - baddr_r0     out  8   compressed byte RAM read address (0..191)
// - bdo_r0       in   8   compressed byte read data, valid 1 cycle after address
// - we_b         out  1   decoded-poly coefficient write strobe
// - addr_b       out  9   decoded-poly coefficient address
// - di_b         out  16  decoded coefficient {2'b00, c[13:0]}
// - we_v         out  1   decompressed coefficient write strobe
// - addr_v       out  9   decompressed coefficient address
// - di_v         out  16  decompressed coefficient {2'b00, d[13:0]}
// - err_range    out  1   sticky flag; present only with PL_DECODE_RANGE_CHECK_EN
// BEHAVIOUR
// - Reset: FSMs to IDLE; all outputs, addresses, accumulators and counters are 0.
// - FSM per engine: IDLE -(start_stage & en)-> RUN -(coef idx N-1 written)-> FIN. Stage goes to IDLE once both engines reach FIN.
// - done_stage is high for exactly the cycle after the later engine's last write, then is 0.
// - Bit accumulator per engine, 24 bits wide:
//   - Each returned byte is appended above the current bit count, LSB-first.
//   - When count >= W (W=14 or 3), the engine emits acc[W-1:0] in that cycle, shifts right by W and subtracts W from count.
// - Fetch rule: issue the next read address only if (count + 8*reads_in_flight) < W+8 and bytes remain.
//   - Addresses are strictly sequential from 0; no byte is ever read twice.
// - Writes: at most one per engine per cycle. Addresses run 0..N-1 in order; we_* is high only in the write cycle.
// - Write data changes only when its we_* is asserted.
// - Decompress datapath:
//   - 3b x 14b -> 17b product; add 4 -> 17b; >>3 -> 14b.
//   - Result registered one cycle before its write, so addr_v/di_v/we_v align.
// - Decode datapath: c = 14-bit field, zero-extended; no modular reduction.
// - en = 0 mid-run: everything freezes, including in-flight reads.
//   - The RAM model is re-read from the held address, so data is valid again when en returns.
// - rst mid-run: immediate abort to IDLE. No done_stage; any partial writes remain in RAM.
// - start_stage while RUN or FIN: ignored. start_stage coincident with rst: reset wins.
// - Final partial accumulator bits must be 0 (exact fit: 896*8 = 512*14, 192*8 = 512*3).
// - Max latency: start_stage to done_stage <= 900 cycles with en held high.
// CONFIGURATION
// - PL_DECODE_RANGE_CHECK_EN defined:
//   - err_range is set when any decoded c >= Q.
//   - It is cleared by rst or by an accepted start_stage.
//   - Coefficients are still written unchanged.
// - PL_DECODE_RANGE_CHECK_EN undefined: err_range port and its logic are absent.
// TESTING
// - All 896+192 bytes = 0x00 -> 512 writes of di_b=0 and 512 writes of di_v=0; one done_stage pulse.
// - Poly bytes 01 80 00 30 00 10 00 repeated -> di_b = 1,2,3,4 repeating at addr_b 0..511.
// - Compressed bytes 88 C6 FA repeated -> di_v = 0,1536,3072,4608,6145,7681,9217,10753 repeating.
// - All poly bytes 0xFF -> di_b = 16383 everywhere; err_range = 1 when the macro is defined.
//   - A second start_stage with zero data clears err_range.
// - Random en deassertion, 30% of cycles, plus a stray start_stage mid-run ->
//   - write sequences identical to the en=1 run; exactly one done_stage.
// - rst asserted at cycle 200 of a run -> all outputs 0 the next cycle, no done_stage.
//   - A fresh start_stage then completes correctly.

Source files
------------

// File: rtl/pl_stage_decode_if.sv
// rtl/pl_stage_decode_if.sv - byte-read and coefficient-write buses of the decode stage
interface pl_stage_decode_if;
    logic [9:0]  baddr_r1;
    logic [7:0]  bdo_r1;
    logic [7:0]  baddr_r0;
    logic [7:0]  bdo_r0;
    logic        we_b;
    logic [8:0]  addr_b;
    logic [15:0] di_b;
    logic        we_v;
    logic [8:0]  addr_v;
    logic [15:0] di_v;

    modport master (
        output baddr_r1, baddr_r0, we_b, addr_b, di_b, we_v, addr_v, di_v,
        input  bdo_r1, bdo_r0
    );

    modport slave (
        input  baddr_r1, baddr_r0, we_b, addr_b, di_b, we_v, addr_v, di_v,
        output bdo_r1, bdo_r0
    );
endinterface

// File: rtl/pl_stage_decode.sv
// rtl/pl_stage_decode.sv - 14-bit poly decode and 3-bit decompress engines; optional PL_DECODE_RANGE_CHECK_EN
module pl_decode_engine #(
    parameter int W  = 14,
    parameter int NB = 896,
    parameter int AW = 10,
    parameter int N  = 512,
    parameter int IW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          start,
    input  logic          clear,
    input  logic [7:0]    rdata,
    output logic [AW-1:0] raddr,
    output logic          emit,
    output logic [W-1:0]  field,
    output logic [IW-1:0] idx,
    output logic          idle,
    output logic          fin
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

    localparam logic [4:0]    WL        = 5'(W);
    localparam logic [4:0]    FETCH_LIM = 5'(W + 8);
    localparam logic [AW-1:0] NB_L      = AW'(NB);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

    state_t        state, state_nx;
    logic [23:0]   acc, acc_in, acc_nx;
    logic [4:0]    cnt, cnt_in, cnt_nx;
    logic          pend;
    logic          issue;
    logic          last;
    logic [AW-1:0] rd_cnt;

    // Append the returning byte, emit one field when enough bits are held, decide the next fetch.
    // While stalled the bus points back at the pending byte so the RAM re-delivers it.
    always_comb begin
        cnt_in = cnt + (pend ? 5'd8 : 5'd0);
        acc_in = pend ? (acc | ({16'd0, rdata} << cnt)) : acc;
        emit   = (state == RUN) && (cnt_in >= WL);
        field  = acc_in[W-1:0];
        acc_nx = emit ? (acc_in >> W) : acc_in;
        cnt_nx = emit ? (cnt_in - WL) : cnt_in;
        issue  = en && (rd_cnt != NB_L) && (cnt_in < FETCH_LIM)
                 && ((state == RUN) || ((state == IDLE) && start));
        last   = emit && (idx == LAST_IDX);
        raddr  = ((pend && !issue) || (rd_cnt == NB_L)) ? (rd_cnt - AW'(1)) : rd_cnt;
        idle   = (state == IDLE);
        fin    = (state == FIN);
    end

    // Next-state: IDLE -> RUN on start, RUN -> FIN on last field, FIN -> IDLE once the stage clears.
    always_comb begin
        state_nx = state;
        if (en) begin
            case (state)
                IDLE:    if (start) state_nx = RUN;
                RUN:     if (last)  state_nx = FIN;
                FIN:     if (clear) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Accumulator, bit count, read and coefficient counters; all frozen while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            pend   <= 1'b0;
            rd_cnt <= '0;
            idx    <= '0;
        end else if (en) begin
            if (state == FIN) begin
                if (clear) begin
                    acc    <= '0;
                    cnt    <= '0;
                    pend   <= 1'b0;
                    rd_cnt <= '0;
                    idx    <= '0;
                end
            end else begin
                acc    <= acc_nx;
                cnt    <= cnt_nx;
                pend   <= issue;
                rd_cnt <= rd_cnt + AW'(issue);
                if (emit) idx <= idx + IW'(1);
            end
        end
    end
endmodule

module pl_stage_decode #(
    parameter int N = 512,
    parameter int Q = 12289
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start_stage,
    output logic               done_stage,
    pl_stage_decode_if.master  bus
`ifdef PL_DECODE_RANGE_CHECK_EN
    ,
    output logic               err_range
`endif
);
    logic        emit_b, emit_v, idle_b, idle_v, fin_b, fin_v, both_fin;
    logic [13:0] field_b;
    logic [2:0]  field_v;
    logic [8:0]  idx_b, idx_v;
    logic [16:0] prod_v, sum_v;
    logic [13:0] dec_v;

    assign both_fin = fin_b && fin_v;

    pl_decode_engine #(.W(14), .NB(896), .AW(10), .N(N), .IW(9)) u_poly (
        .clk(clk), .rst(rst), .en(en), .start(start_stage), .clear(both_fin),
        .rdata(bus.bdo_r1), .raddr(bus.baddr_r1), .emit(emit_b), .field(field_b),
        .idx(idx_b), .idle(idle_b), .fin(fin_b)
    );

    pl_decode_engine #(.W(3), .NB(192), .AW(8), .N(N), .IW(9)) u_comp (
        .clk(clk), .rst(rst), .en(en), .start(start_stage), .clear(both_fin),
        .rdata(bus.bdo_r0), .raddr(bus.baddr_r0), .emit(emit_v), .field(field_v),
        .idx(idx_v), .idle(idle_v), .fin(fin_v)
    );

    // Decompress: round-to-nearest of x*Q/8 using a 17-bit product.
    always_comb begin
        prod_v = 17'(field_v) * 17'(Q);
        sum_v  = prod_v + 17'd4;
        dec_v  = sum_v[16:3];
    end

    // Coefficient write ports and done pulse; strobes are single-cycle events, data holds between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_stage <= 1'b0;
            bus.we_b   <= 1'b0;
            bus.addr_b <= '0;
            bus.di_b   <= '0;
            bus.we_v   <= 1'b0;
            bus.addr_v <= '0;
            bus.di_v   <= '0;
        end else begin
            done_stage <= en && both_fin;
            bus.we_b   <= en && emit_b;
            bus.we_v   <= en && emit_v;
            if (en && emit_b) begin
                bus.addr_b <= idx_b;
                bus.di_b   <= {2'b00, field_b};
            end
            if (en && emit_v) begin
                bus.addr_v <= idx_v;
                bus.di_v   <= {2'b00, dec_v};
            end
        end
    end

`ifdef PL_DECODE_RANGE_CHECK_EN
    // Sticky out-of-range flag on decoded coefficients, cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_range <= 1'b0;
        end else if (en) begin
            if (start_stage && idle_b && idle_v) err_range <= 1'b0;
            else if (emit_b && ({2'b00, field_b} >= 16'(Q))) err_range <= 1'b1;
        end
    end
`else
    logic unused_idle;
    assign unused_idle = idle_b & idle_v;
`endif
endmodule

// File: tb/tb_pl_stage_decode.sv
// tb/tb_pl_stage_decode.sv - bench for pl_stage_decode against a bit-extraction model
module tb_pl_stage_decode;
    localparam int N   = 512;
    localparam int Q   = 12289;
    localparam int NBB = 896;
    localparam int NBV = 192;

    logic clk = 1'b0;
    logic rst, en, start_stage, done_stage;
`ifdef PL_DECODE_RANGE_CHECK_EN
    logic err_range;
`endif

    pl_stage_decode_if bus();

    pl_stage_decode dut (
        .clk(clk), .rst(rst), .en(en), .start_stage(start_stage),
        .done_stage(done_stage), .bus(bus)
`ifdef PL_DECODE_RANGE_CHECK_EN
        , .err_range(err_range)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] mem_b [0:NBB-1];
    logic [7:0] mem_v [0:NBV-1];
    logic [7:0] pat_b [0:6] = '{8'h01, 8'h80, 8'h00, 8'h30, 8'h00, 8'h10, 8'h00};
    logic [7:0] pat_v [0:2] = '{8'h88, 8'hC6, 8'hFA};
    int exp_b [0:N-1];
    int exp_v [0:N-1];
    int vectors = 0;
    int errors  = 0;
    int wb, wv, done_cnt;
    bit watch = 1'b0;
    logic [15:0] prev_b, prev_v;

    // RAMs: one-cycle read latency from whatever address is on the bus.
    always @(posedge clk) begin
        bus.bdo_r1 <= (bus.baddr_r1 < 10'(NBB)) ? mem_b[bus.baddr_r1] : 8'h00;
        bus.bdo_r0 <= (bus.baddr_r0 < 8'(NBV)) ? mem_v[bus.baddr_r0] : 8'h00;
    end

    task automatic check(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic void build_model();
        for (int i = 0; i < N; i++) begin
            int c;
            int x;
            c = 0;
            x = 0;
            for (int b = 0; b < 14; b++) begin
                int p;
                p = 14 * i + b;
                if (mem_b[p / 8][p % 8]) c += (1 << b);
            end
            for (int b = 0; b < 3; b++) begin
                int p;
                p = 3 * i + b;
                if (mem_v[p / 8][p % 8]) x += (1 << b);
            end
            exp_b[i] = c;
            exp_v[i] = (x * Q + 4) / 8;
        end
    endfunction

    task automatic load(input int kind_b, input int kind_v);
        for (int i = 0; i < NBB; i++)
            case (kind_b)
                0: mem_b[i] = 8'h00;
                1: mem_b[i] = pat_b[i % 7];
                2: mem_b[i] = 8'hFF;
                default: mem_b[i] = 8'($urandom_range(0, 255));
            endcase
        for (int i = 0; i < NBV; i++)
            case (kind_v)
                0: mem_v[i] = 8'h00;
                1: mem_v[i] = pat_v[i % 3];
                default: mem_v[i] = 8'($urandom_range(0, 255));
            endcase
        build_model();
    endtask

    task automatic cmp();
        if (watch) begin
            if (bus.we_b) begin
                if (wb < N) begin
                    check("wr_b_addr", int'(bus.addr_b), wb);
                    check("wr_b_data", int'(bus.di_b), exp_b[wb]);
                end else check("wr_b_extra", wb, N - 1);
                wb++;
            end else check("hold_di_b", int'(bus.di_b), int'(prev_b));
            if (bus.we_v) begin
                if (wv < N) begin
                    check("wr_v_addr", int'(bus.addr_v), wv);
                    check("wr_v_data", int'(bus.di_v), exp_v[wv]);
                end else check("wr_v_extra", wv, N - 1);
                wv++;
            end else check("hold_di_v", int'(bus.di_v), int'(prev_v));
            if (done_stage) begin
                done_cnt++;
                check("done_after_b", wb, N);
                check("done_after_v", wv, N);
            end
        end
        prev_b = bus.di_b;
        prev_v = bus.di_v;
    endtask

    task automatic cyc();
        @(negedge clk);
        cmp();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_done"}, int'(done_stage), 0);
        check({tag, "_we_b"}, int'(bus.we_b), 0);
        check({tag, "_we_v"}, int'(bus.we_v), 0);
        check({tag, "_addr_b"}, int'(bus.addr_b), 0);
        check({tag, "_addr_v"}, int'(bus.addr_v), 0);
        check({tag, "_di_b"}, int'(bus.di_b), 0);
        check({tag, "_di_v"}, int'(bus.di_v), 0);
        check({tag, "_baddr_r1"}, int'(bus.baddr_r1), 0);
        check({tag, "_baddr_r0"}, int'(bus.baddr_r0), 0);
    endtask

    task automatic run_stage(input bit rand_en, input bit stray, input int max_lat);
        int t;
        int lat;
        int post;
        wb = 0;
        wv = 0;
        done_cnt = 0;
        watch = 1'b1;
        en = 1'b1;
        start_stage = 1'b1;
        cyc();
        start_stage = 1'b0;
        t = 1;
        lat = -1;
        post = 0;
        for (int i = 0; i < 3000 && post < 4; i++) begin
            en = rand_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
            start_stage = stray && (i == 300);
            cyc();
            t++;
            if (done_stage && lat < 0) lat = t;
            if (lat >= 0) post++;
        end
        en = 1'b1;
        start_stage = 1'b0;
        watch = 1'b0;
        check("writes_b", wb, N);
        check("writes_v", wv, N);
        check("done_pulses", done_cnt, 1);
        if (max_lat > 0) check("latency_ok", int'(lat > 0 && lat <= max_lat), 1);
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        en = 1'b0;
        start_stage = 1'b0;
        load(0, 0);
        repeat (3) cyc();
        check_zero("reset");
`ifdef PL_DECODE_RANGE_CHECK_EN
        check("reset_err_range", int'(err_range), 0);
`endif
        rst = 1'b0;
        en = 1'b1;
        cyc();

        // all-zero data
        check("model_zero", exp_b[37] + exp_v[200], 0);
        run_stage(1'b0, 1'b0, 900);

        // repeating patterns
        load(1, 1);
        check("model_b0", exp_b[0], 1);
        check("model_b1", exp_b[1], 2);
        check("model_b2", exp_b[2], 3);
        check("model_b3", exp_b[3], 4);
        check("model_b511", exp_b[511], 4);
        check("model_v2", exp_v[2], 3072);
        check("model_v4", exp_v[4], 6145);
        check("model_v7", exp_v[7], 10753);
        check("model_v511", exp_v[511], 10753);
        run_stage(1'b0, 1'b0, 900);

        // all-ones poly data: every coefficient out of range
        load(2, 1);
        check("model_ff0", exp_b[0], 16383);
        check("model_ff511", exp_b[511], 16383);
        run_stage(1'b0, 1'b0, 900);
`ifdef PL_DECODE_RANGE_CHECK_EN
        check("err_range_set", int'(err_range), 1);
`endif
        load(0, 0);
        run_stage(1'b0, 1'b0, 900);
`ifdef PL_DECODE_RANGE_CHECK_EN
        check("err_range_cleared", int'(err_range), 0);
`endif

        // random data with en stalls and a stray start
        load(3, 3);
        run_stage(1'b1, 1'b1, 0);

        // reset mid-run
        load(3, 3);
        wb = 0;
        wv = 0;
        done_cnt = 0;
        watch = 1'b1;
        start_stage = 1'b1;
        cyc();
        start_stage = 1'b0;
        repeat (199) cyc();
        watch = 1'b0;
        check("partial_writes_b", int'(wb > 100 && wb < N), 1);
        rst = 1'b1;
        cyc();
        check_zero("rst_mid");
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc();
            cnt += int'(done_stage) + int'(bus.we_b) + int'(bus.we_v);
        end
        check("no_activity_after_rst", cnt, 0);

        // start coincident with reset is dropped
        rst = 1'b1;
        start_stage = 1'b1;
        cyc();
        rst = 1'b0;
        start_stage = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            cnt += int'(done_stage) + int'(bus.we_b) + int'(bus.we_v);
        end
        check("start_with_rst_ignored", cnt, 0);

        // fresh run after the abort
        run_stage(1'b0, 1'b0, 900);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
